// File: rtl/program_loader_pkg.sv
// program_loader shared types: FSM state encoding and command bytes.
// Imported by the loader top and its byte assembler.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    RUN
  } state_t;

  localparam logic [7:0] CMD_LOAD_IMEM = 8'h01;
  localparam logic [7:0] CMD_LOAD_DMEM = 8'h02;
  localparam logic [7:0] CMD_START     = 8'h03;
  localparam logic [7:0] CMD_STOP      = 8'h04;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream valid/ready channel into the program loader.
// master drives s_data/s_valid, slave returns s_ready.
interface program_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Little-endian byte-to-word packer, 4-byte or 8-byte mode.
// Ports: clr/mode8/in_valid/in_byte in; word_nxt/word_done out.
module byte_assembler (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        clr,
  input  logic        mode8,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [63:0] word_nxt,
  output logic        word_done
);

  logic [63:0] word;
  logic [2:0]  cnt;
  logic [2:0]  last;

  assign last      = mode8 ? 3'd7 : 3'd3;
  assign word_done = in_valid && (cnt == last);

  // word_nxt already holds the byte being accepted, so
  // the caller can latch a complete word on word_done.
  always_comb begin
    word_nxt = word;
    word_nxt[{cnt, 3'b000} +: 8] = in_byte;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (in_valid) begin
      word <= word_nxt;
      cnt  <= word_done ? 3'd0 : cnt + 3'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream loader for the cpu imem/dmem ext ports and run enable.
// Ports: s (stream slave), *_ext imem, *_ext_2 dmem, enable, busy, err.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              arst_n,
  program_loader_if.slave   s,
  output logic [63:0]       addr_ext,
  output logic              wen_ext,
  output logic [31:0]       wdata_ext,
  output logic [63:0]       addr_ext_2,
  output logic              wen_ext_2,
  output logic [63:0]       wdata_ext_2,
  output logic              enable,
  output logic              busy,
  output logic              err
);

  localparam logic [16:0] I_LIM = 17'(IMEM_WORDS);
  localparam logic [16:0] D_LIM = 17'(DMEM_WORDS);

  state_t      state;
  state_t      nxt;
  logic        accept;
  logic        sel_d;
  logic [7:0]  cnt_lo;
  logic [15:0] left;
  logic [15:0] idx;
  logic [63:0] word_nxt;
  logic        word_done;
  logic        is_load;
  logic        is_start;
  logic        in_rng;

  assign accept   = s.s_valid && s.s_ready;
  assign is_load  = (s.s_data == CMD_LOAD_IMEM) ||
                    (s.s_data == CMD_LOAD_DMEM);
  assign is_start = (s.s_data == CMD_START);
  assign in_rng   = sel_d ? ({1'b0, idx} < D_LIM)
                          : ({1'b0, idx} < I_LIM);

  byte_assembler u_asm (
    .clk       (clk),
    .arst_n    (arst_n),
    .clr       (state != DATA),
    .mode8     (sel_d),
    .in_valid  (accept && (state == DATA)),
    .in_byte   (s.s_data),
    .word_nxt  (word_nxt),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) begin
        unique case (1'b1)
          is_load:  nxt = LEN_LO;
          is_start: nxt = RUN;
          default:  nxt = IDLE;
        endcase
      end
      LEN_LO: if (accept) nxt = LEN_HI;
      LEN_HI: if (accept) begin
        nxt = ({s.s_data, cnt_lo} == 16'd0) ? IDLE : DATA;
      end
      DATA:  if (word_done) nxt = WRITE;
      WRITE: nxt = (left == 16'd1) ? IDLE : DATA;
      RUN: if (accept && s.s_data == CMD_STOP) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    s.s_ready = (state != WRITE);
    busy      = (state != IDLE) && (state != RUN);
    enable    = (state == RUN);
  end

  // Strobes are set on the last payload byte so they are
  // high during WRITE only; address/data latch alongside.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      err         <= 1'b0;
      sel_d       <= 1'b0;
      cnt_lo      <= '0;
      left        <= '0;
      idx         <= '0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (is_load) sel_d <= (s.s_data == CMD_LOAD_DMEM);
          err <= !(is_load || is_start);
        end
        LEN_LO: if (accept) cnt_lo <= s.s_data;
        LEN_HI: if (accept) begin
          left <= {s.s_data, cnt_lo};
          idx  <= '0;
        end
        DATA: if (word_done) begin
          if (!in_rng) begin
            err <= 1'b1;
          end else if (sel_d) begin
            wen_ext_2   <= 1'b1;
            addr_ext_2  <= {45'b0, idx, 3'b000};
            wdata_ext_2 <= word_nxt;
          end else begin
            wen_ext   <= 1'b1;
            addr_ext  <= {46'b0, idx, 2'b00};
            wdata_ext <= word_nxt[31:0];
          end
        end
        WRITE: begin
          idx  <= idx + 16'd1;
          left <= left - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream front-end for the `cpu` top: it accepts a byte stream over a valid/ready handshake, assembles little-endian words and writes them through the external ports of the instruction memory (32-bit) and data memory (64-bit). On command it drives `enable` to start execution, and on another command it drops `enable` to stop. It owns the CPU's `enable` input and the `*_ext` write ports, so a test harness or UART bridge only has to produce bytes.

## Interface
- `IMEM_WORDS`, default 512: instruction-memory capacity in 32-bit words (matches ADDR_W 9).
- `DMEM_WORDS`, default 1024: data-memory capacity in 64-bit words (matches ADDR_W 10).
- `clk  in  1`: system clock; all state updates on the rising edge.
- `arst_n  in  1`: reset, asynchronous and active-low.
- `s_data  in  8`: stream byte.
- `s_valid  in  1`: `s_data` is valid.
- `s_ready  out  1`: loader can accept a byte. Transfer occurs when `s_valid & s_ready`.
- `addr_ext  out  64`: instruction-memory byte address.
- `wen_ext  out  1`: instruction-memory write strobe.
- `wdata_ext  out  32`: instruction word.
- `addr_ext_2  out  64`: data-memory byte address.
- `wen_ext_2  out  1`: data-memory write strobe.
- `wdata_ext_2  out  64`: data doubleword.
- `enable  out  1`: CPU run enable.
- `busy  out  1`: a load is in progress (state is not IDLE or RUN).
- `err  out  1`: sticky protocol or overflow error.

## Operation
- Command bytes, accepted in IDLE:
  - 0x01 selects LOAD_IMEM.
  - 0x02 selects LOAD_DMEM.
  - 0x03 selects START.
  - Any other value is consumed, sets `err`, and the FSM stays in IDLE.
- Accepting 0x01, 0x02 or 0x03 clears `err`.
- States and transitions:
  - IDLE: 0x01/0x02 go to LEN_LO; 0x03 goes to RUN.
  - LEN_LO: capture count[7:0], go to LEN_HI.
  - LEN_HI: capture count[15:8]. If count==0, return to IDLE with no writes; otherwise go to DATA.
  - DATA: collect 4 bytes (imem) or 8 bytes (dmem), little-endian (first byte goes to [7:0]). After the last byte, go to WRITE.
  - WRITE: pulse the strobe for one cycle and increment the word index. If words remaining == 0, go to IDLE; otherwise go to DATA.
  - RUN: `enable`=1. Byte 0x04 goes to IDLE with `enable`=0. Every other byte is consumed and ignored; loads are never accepted while running.
- Address generation:
  - Each load starts at word index 0.
  - Imem address is `{index, 2'b00}`; dmem address is `{index, 3'b000}`. Upper bits are zero.
- Overflow: a word whose index is ≥ IMEM_WORDS (or ≥ DMEM_WORDS for dmem) is consumed but not written (strobe stays low), and `err` is set. The rest of the stream is still consumed to its count.
- Output lines never pulse: only the selected memory's strobe is ever asserted; the other stays low.

## Timing
- `s_ready`=1 in IDLE, LEN_LO, LEN_HI, DATA and RUN; 0 in WRITE.
- Latency: the strobe is asserted the cycle after the last payload byte is accepted. Address and wdata are registered and stable in that same cycle. Strobe is high for exactly one cycle.
- Throughput: one word per 5 cycles (imem) or 9 cycles (dmem) at full `s_valid`.
- `enable` rises the cycle after 0x03 is accepted and falls the cycle after 0x04 is accepted.
- `s_valid` gaps in any state stall the FSM with no side effects. A partial word is held indefinitely.
- Reset values: state IDLE; `s_ready`=1; all addresses, wdata, strobes, `enable`, `busy` and `err` are 0; byte and word counters are 0.
- Reset mid-load aborts immediately and counters clear. Memory words already written are not rolled back.
- Count 0xFFFF is legal; the index counter is 16 bits wide and does not wrap before the count expires.

## Structure
- Shared package or header holds:
  - State encoding: IDLE, LEN_LO, LEN_HI, DATA, WRITE, RUN.
  - Command constants: CMD_LOAD_IMEM=0x01, CMD_LOAD_DMEM=0x02, CMD_START=0x03, CMD_STOP=0x04.
- Sub-module `byte_assembler`: 64-bit little-endian shift/insert register with a 3-bit byte counter and a `word_done` output for 4- or 8-byte mode. The FSM, counters and address generation stay in the top.

## Test plan
- Imem load: 0x01, 0x02, 0x00, then bytes 13 00 00 00, B3 00 10 00 → two `wen_ext` pulses, addr 0x0 data 0x00000013 and addr 0x4 data 0x001000B3; `busy` falls after the second pulse.
- Dmem load: 0x02, 0x01, 0x00, then 01..08 → one `wen_ext_2` pulse, addr 0x0, data 0x0807060504030201; `wen_ext` never rises.
- Run control: 0x03 → `enable`=1 the next cycle; bytes 0x01 and 0x55 → ignored, `enable` stays 1; 0x04 → `enable`=0 and state returns to IDLE.
- Overflow with IMEM_WORDS=2: load of 3 words → two writes (addr 0x0, 0x4), third word consumed without a strobe, `err`=1; next 0x03 clears `err`.
- Edge cases:
  - Bad command 0x7F → `err`=1 and no writes.
  - Count 0 → returns to IDLE without any strobe.
- Throttling and reset: random `s_valid` gaps give identical writes; `arst_n` low after 2 of 4 payload bytes → all outputs 0, and a fresh load then writes at addr 0x0.
